// File: rtl/fpu_norm_round.sv
// Two-stage normaliser + round-to-nearest-even packer with valid/ready on both sides.
// Optional macro FPU_NORM_SUBNORM_EN selects gradual underflow instead of flush-to-zero.
module fpu_norm_round #(
    parameter int EXPW   = 5,
    parameter int FRACW  = 10,
    parameter int GUARDW = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign,
    input  logic [EXPW-1:0]            in_exp,
    input  logic [FRACW+GUARDW+1:0]    in_mant,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXPW+FRACW:0]        out_fp,
    output logic                       out_overflow,
    output logic                       out_underflow,
    output logic                       out_inexact
);
    localparam int NW  = FRACW + GUARDW + 1;
    localparam int MW  = NW + 1;
    localparam int LZW = $clog2(MW);
    localparam int CW  = EXPW + LZW;
    localparam logic [EXPW-1:0] EXP_MAX = {EXPW{1'b1}};

    logic                s1_valid_q, s1_sign_q, s1_bypass_q, s1_unf_q, s1_inx_q;
    logic [EXPW-1:0]     s1_exp_q;
    logic [NW-1:0]       s1_mant_q;
    logic                s1_bypass_d, s1_unf_d, s1_inx_d;
    logic [EXPW-1:0]     s1_exp_d;
    logic [NW-1:0]       s1_mant_d;

    logic                s2_valid_q, ovf_q, unf_q, inx_q;
    logic [EXPW+FRACW:0] fp_q;
    logic                ovf_d, unf_d, inx_d;
    logic [EXPW+FRACW:0] fp_d;

    logic                s1_adv, s2_adv;
    logic [LZW-1:0]      lzc;
    logic                lz_ge_exp;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_fp        = fp_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

    // Leading zeros below the carry bit; the highest set bit wins.
    always_comb begin
        lzc = LZW'(NW);
        for (int i = 0; i < NW; i++) begin
            if (in_mant[i]) lzc = LZW'(NW - 1 - i);
        end
    end

    assign lz_ge_exp = CW'(lzc) >= CW'(in_exp);

    always_comb begin
        s1_bypass_d = 1'b0;
        s1_unf_d    = 1'b0;
        s1_inx_d    = 1'b0;
        s1_exp_d    = in_exp;
        s1_mant_d   = in_mant[NW-1:0];
        if (in_exp == EXP_MAX) begin
            s1_bypass_d = 1'b1;
            s1_mant_d   = '0;
            s1_mant_d[NW-2:GUARDW] = in_mant[NW-2:GUARDW];
            if (|in_mant[NW-2:GUARDW]) s1_mant_d[NW-2] = 1'b1;
        end else if (in_mant == '0) begin
            s1_bypass_d = 1'b1;
            s1_exp_d    = '0;
            s1_mant_d   = '0;
        end else if (in_mant[MW-1]) begin
            s1_mant_d    = in_mant[MW-1:1];
            s1_mant_d[0] = in_mant[1] | in_mant[0];
            s1_exp_d     = in_exp + 1'b1;
        end else if (!lz_ge_exp) begin
            s1_mant_d = in_mant[NW-1:0] << lzc;
            s1_exp_d  = in_exp - EXPW'(lzc);
        end else begin
`ifdef FPU_NORM_SUBNORM_EN
            s1_exp_d = '0;
            if (in_exp != '0) s1_mant_d = in_mant[NW-1:0] << (in_exp - 1'b1);
`else
            s1_bypass_d = 1'b1;
            s1_exp_d    = '0;
            s1_mant_d   = '0;
            s1_unf_d    = 1'b1;
            s1_inx_d    = |in_mant;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_unf_q    <= 1'b0;
            s1_inx_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_sign;
                s1_bypass_q <= s1_bypass_d;
                s1_unf_q    <= s1_unf_d;
                s1_inx_q    <= s1_inx_d;
                s1_exp_q    <= s1_exp_d;
                s1_mant_q   <= s1_mant_d;
            end
        end
    end

    logic                g_bit, t_bit, l_bit, round_up;
    logic [FRACW+1:0]    rnd_sum;
    logic [EXPW-1:0]     exp_r;
    logic [FRACW-1:0]    frac_r;

    assign g_bit    = s1_mant_q[GUARDW-1];
    assign t_bit    = |s1_mant_q[GUARDW-2:0];
    assign l_bit    = s1_mant_q[GUARDW];
    assign round_up = g_bit & (t_bit | l_bit);
    assign rnd_sum  = {1'b0, s1_mant_q[NW-1:GUARDW]} + {{(FRACW+1){1'b0}}, round_up};

    always_comb begin
        exp_r  = s1_exp_q;
        frac_r = s1_mant_q[NW-2:GUARDW];
        ovf_d  = 1'b0;
        unf_d  = s1_unf_q;
        inx_d  = s1_inx_q;
        if (!s1_bypass_q) begin
            inx_d  = g_bit | t_bit;
            unf_d  = (s1_exp_q == '0) && (g_bit | t_bit);
            frac_r = rnd_sum[FRACW-1:0];
            if (rnd_sum[FRACW+1]) begin
                exp_r  = s1_exp_q + 1'b1;
                frac_r = rnd_sum[FRACW:1];
            end else if (s1_exp_q == '0 && rnd_sum[FRACW]) begin
                exp_r = EXPW'(1);
            end
            // A carry-normalised all-ones exponent is checked first so the +1 cannot wrap.
            if (s1_exp_q == EXP_MAX || exp_r == EXP_MAX) begin
                exp_r  = EXP_MAX;
                frac_r = '0;
                ovf_d  = 1'b1;
                inx_d  = 1'b1;
            end
        end
        fp_d = {s1_sign_q, exp_r, frac_r};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            fp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                fp_q  <= fp_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
                inx_q <= inx_d;
            end
        end
    end
endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed-vector bench for fpu_norm_round at EXPW=5, FRACW=10, GUARDW=3.
module tb_fpu_norm_round;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, in_sign, out_valid, out_ready;
    logic [4:0]  in_exp;
    logic [14:0] in_mant;
    logic [15:0] out_fp;
    logic        out_overflow, out_underflow, out_inexact;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    fpu_norm_round #(.EXPW(5), .FRACW(10), .GUARDW(3)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    // Sends one operand into an empty pipeline and waits (bounded) for its result.
    task automatic do_txn(input logic s, input logic [4:0] e, input logic [14:0] m,
                          output logic [15:0] fp, output logic ov, output logic un,
                          output logic ix, output int lat);
        @(negedge clock);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        fp = out_fp; ov = out_overflow; un = out_underflow; ix = out_inexact;
        $display("txn sign=%b exp=%0d mant=%b -> fp=%h ovf=%b unf=%b inx=%b lat=%0d",
                 s, e, m, fp, ov, un, ix, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_fp !== 16'h0000) begin n_fail++; $display("FAIL reset_fp: got %h want 0000", out_fp); end
        n_checks++; if ({out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {out_overflow, out_underflow, out_inexact}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_carry();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd15, {1'b1, 1'b0, 10'b0000000000, 3'b000}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h4000) begin n_fail++; $display("FAIL carry_fp: got %h want 4000", fp); end
        n_checks++; if ({ov, un, ix} !== 3'b000) begin n_fail++; $display("FAIL carry_flags: got %b want 000", {ov, un, ix}); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL carry_latency: got %0d want 2", lat); end
    endtask

    task automatic test_leading_zeros();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd15, {1'b0, 1'b0, 10'b0100000000, 3'b000}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h3400) begin n_fail++; $display("FAIL lz_fp: got %h want 3400", fp); end
        n_checks++; if ({ov, un, ix} !== 3'b000) begin n_fail++; $display("FAIL lz_flags: got %b want 000", {ov, un, ix}); end
    endtask

    task automatic test_tie_rounding();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd15, {1'b0, 1'b1, 10'b0000000001, 3'b100}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h3C02) begin n_fail++; $display("FAIL tie_odd_fp: got %h want 3C02", fp); end
        n_checks++; if (ix !== 1'b1) begin n_fail++; $display("FAIL tie_odd_inexact: got %b want 1", ix); end
        do_txn(1'b0, 5'd15, {1'b0, 1'b1, 10'b0000000000, 3'b100}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h3C00) begin n_fail++; $display("FAIL tie_even_fp: got %h want 3C00", fp); end
        n_checks++; if (ix !== 1'b1) begin n_fail++; $display("FAIL tie_even_inexact: got %b want 1", ix); end
        do_txn(1'b1, 5'd15, {1'b0, 1'b1, 10'b0000000000, 3'b101}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'hBC01) begin n_fail++; $display("FAIL above_half_fp: got %h want BC01", fp); end
    endtask

    task automatic test_overflow();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd30, {1'b0, 1'b1, 10'b1111111111, 3'b111}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h7C00) begin n_fail++; $display("FAIL ovf_fp: got %h want 7C00", fp); end
        n_checks++; if ({ov, ix} !== 2'b11) begin n_fail++; $display("FAIL ovf_flags: got ovf=%b inx=%b want 1 1", ov, ix); end
        do_txn(1'b1, 5'd30, {1'b1, 1'b0, 10'b0000000000, 3'b000}, fp, ov, un, ix, lat);
        n_checks++; if ({fp, ov, ix} !== {16'hFC00, 2'b11}) begin
            n_fail++; $display("FAIL carry_ovf: got %h ovf=%b inx=%b want FC00 1 1", fp, ov, ix); end
    endtask

    task automatic test_underflow();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd2, {1'b0, 1'b0, 10'b0010000000, 3'b000}, fp, ov, un, ix, lat);
`ifdef FPU_NORM_SUBNORM_EN
        n_checks++; if (fp !== 16'h0100) begin n_fail++; $display("FAIL unf_fp: got %h want 0100", fp); end
        n_checks++; if ({un, ix} !== 2'b00) begin n_fail++; $display("FAIL unf_flags: got unf=%b inx=%b want 0 0", un, ix); end
`else
        n_checks++; if (fp !== 16'h0000) begin n_fail++; $display("FAIL unf_fp: got %h want 0000", fp); end
        n_checks++; if ({un, ix} !== 2'b11) begin n_fail++; $display("FAIL unf_flags: got unf=%b inx=%b want 1 1", un, ix); end
`endif
        do_txn(1'b0, 5'd1, {1'b0, 1'b0, 10'b1111111111, 3'b100}, fp, ov, un, ix, lat);
`ifdef FPU_NORM_SUBNORM_EN
        n_checks++; if (fp !== 16'h0400) begin n_fail++; $display("FAIL sub_round_fp: got %h want 0400", fp); end
`else
        n_checks++; if (fp !== 16'h0000) begin n_fail++; $display("FAIL sub_round_fp: got %h want 0000", fp); end
`endif
        n_checks++; if ({un, ix} !== 2'b11) begin n_fail++; $display("FAIL sub_round_flags: got unf=%b inx=%b want 1 1", un, ix); end
    endtask

    task automatic test_special_zero();
        logic [15:0] fp; logic ov, un, ix; int lat;
        do_txn(1'b0, 5'd31, {1'b0, 1'b1, 10'b0000000001, 3'b111}, fp, ov, un, ix, lat);
        n_checks++; if (fp !== 16'h7E01) begin n_fail++; $display("FAIL nan_fp: got %h want 7E01", fp); end
        n_checks++; if ({ov, un, ix} !== 3'b000) begin n_fail++; $display("FAIL nan_flags: got %b want 000", {ov, un, ix}); end
        do_txn(1'b1, 5'd31, {1'b0, 1'b1, 10'b0000000000, 3'b000}, fp, ov, un, ix, lat);
        n_checks++; if ({fp, ov} !== {16'hFC00, 1'b0}) begin n_fail++; $display("FAIL inf_pass: got %h ovf=%b want FC00 0", fp, ov); end
        do_txn(1'b1, 5'd10, 15'd0, fp, ov, un, ix, lat);
        n_checks++; if ({fp, ov, un, ix} !== {16'h8000, 3'b000}) begin
            n_fail++; $display("FAIL zero: got %h flags=%b want 8000 000", fp, {ov, un, ix}); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ve[4];
        logic [14:0] vm[4];
        logic [15:0] vf[4];
        logic [15:0] stall_fp;
        int sent, recv, gaps, cyc;
        ve[0] = 5'd15; vm[0] = {1'b1, 1'b0, 10'b0000000000, 3'b000}; vf[0] = 16'h4000;
        ve[1] = 5'd15; vm[1] = {1'b0, 1'b0, 10'b0100000000, 3'b000}; vf[1] = 16'h3400;
        ve[2] = 5'd15; vm[2] = {1'b0, 1'b1, 10'b0000000001, 3'b100}; vf[2] = 16'h3C02;
        ve[3] = 5'd15; vm[3] = {1'b0, 1'b1, 10'b0000000000, 3'b100}; vf[3] = 16'h3C00;
        sent = 0; recv = 0; gaps = 0; cyc = 0; stall_fp = '0;
        while (recv < 4 && cyc < 40) begin
            @(negedge clock);
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            in_sign   = 1'b0;
            if (sent < 4) begin in_exp = ve[sent]; in_mant = vm[sent]; end
            #1;
            if (cyc == 2) begin
                n_checks++; if (sent !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", sent); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
                stall_fp = out_fp;
            end
            if (cyc == 3) begin
                n_checks++; if (out_fp !== stall_fp || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_stall_hold: got %h valid=%b want %h valid=1", out_fp, out_valid, stall_fp); end
            end
            if (out_valid && out_ready) begin
                $display("txn b2b result %0d fp=%h", recv, out_fp);
                n_checks++; if (out_fp !== vf[recv]) begin
                    n_fail++; $display("FAIL b2b_order_%0d: got %h want %h", recv, out_fp, vf[recv]); end
                recv++;
            end else if (recv > 0) begin
                gaps++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        n_checks++; if (recv !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", recv); end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end

        // Fill the pipe while stalled, then reset: both in-flight results must vanish.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_exp = ve[i]; in_mant = vm[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_prefill: got valid=%b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if ({out_valid, out_fp} !== {1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL rst_mid_stall: got valid=%b fp=%h want 0 0000", out_valid, out_fp); end
        out_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_valid) gaps++;
        end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL rst_discard: got %0d stray results want 0", gaps); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_leading_zeros();
        test_tie_rounding();
        test_overflow();
        test_underflow();
        test_special_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_norm_round.md
# fpu_norm_round

Parametrised, two-stage pipelined normaliser and rounder for the FPU datapath, generalising the half-precision combinational normaliser to any exponent/fraction width. It takes an unnormalised sign/exponent/mantissa from the adder or multiplier (carry bit, hidden bit, fraction and guard bits), then:
- normalises it,
- rounds to nearest-even,
- handles overflow and underflow,
- returns a packed IEEE-style word plus exception flags.

Valid/ready handshakes on both sides let it sit between the arithmetic core and the result writeback.

## Interface
Parameters:
- EXPW, 5, exponent width; bias = 2^(EXPW-1)-1.
- FRACW, 10, stored fraction width.
- GUARDW, 3, extra low-order bits below the fraction used for rounding (≥2).

Ports (MW = FRACW+GUARDW+2):
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_sign  input  1  sign.
- in_exp  input  EXPW  biased exponent; binary point sits just below the hidden bit.
- in_mant  input  MW  bit MW-1 = carry (weight 2), bit MW-2 = hidden (weight 1), then FRACW fraction bits, then GUARDW guard bits.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_fp  output  1+EXPW+FRACW  packed {sign, exp, frac}.
- out_overflow  output  1  result rounded to infinity.
- out_underflow  output  1  result tiny and inexact.
- out_inexact  output  1  result differs from the exact value.

## Operation
Stage 1 normalises and registers the result. Cases are checked in order:
- **Special:** in_exp all-ones → pass through with exp all-ones and frac = in_mant fraction field. A nonzero frac gets its MSB forced to 1 (quiet NaN). No flags, no rounding.
- **Zero:** in_mant == 0 → signed zero, exact.
- **Carry set:** shift right 1, OR the shifted-out bit into the LSB (sticky), exp+1.
- **Normal:** lzc = leading zeros counted from the hidden bit. If lzc < in_exp, shift left by lzc and set exp = in_exp − lzc.
- **Underflow** (lzc ≥ in_exp): handled per Configuration.

Stage 2 rounds and packs (round to nearest even):
- G = top guard bit; T = OR of the remaining guard bits; L = fraction LSB.
- Round up when G & (T | L).
- inexact = G | T.
- The increment covers the hidden and fraction bits:
  - Carry out of the hidden position → shift right 1, exp+1.
  - A subnormal that rounds up into the hidden bit → exp becomes 1.
- exp reaching all-ones after normalise or round → ±infinity (frac 0), overflow=1, inexact=1.

Packing: out_fp = {sign, exp, frac}; the hidden bit is dropped.

## Timing
- **Reset:** clears both stage valids, out_valid=0, out_fp=0, all flags 0. A reset asserted mid-operation discards in-flight operands without producing output.
- **Latency:** 2 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
- **Throughput:** one result per cycle.
- **Stage 2 advances** when it is empty or (out_valid & out_ready).
- **Stage 1 advances** when it is empty or stage 2 advances.
- **in_ready** = stage 1 empty | stage 2 advances.
  - Combinational from out_ready; no path from in_valid.
- **Stall:** while out_valid & !out_ready, out_fp and the flags hold stable.
- **Ordering:** results leave in acceptance order; none are dropped or duplicated.
- **Simultaneous accept and drain** in the same cycle is legal and keeps full throughput.
- **Flags** travel with their result and are valid only when out_valid=1.

## Configuration
Macro FPU_NORM_SUBNORM_EN controls the underflow case (lzc ≥ in_exp).
- **Defined** (gradual underflow):
  - Shift left by max(in_exp−1, 0); exp = 0.
  - Round normally.
  - underflow = (result exp 0 before rounding) & inexact.
- **Undefined** (flush to zero):
  - Result is signed zero.
  - underflow = 1.
  - inexact = (in_mant ≠ 0).

## Test plan
Defaults EXPW=5, FRACW=10, GUARDW=3. Mantissas are written carry_hidden_frac_guard.
- **Carry:** in_exp=15, in_mant=1_0_0000000000_000 → 2 cycles later out_fp=16'h4000, all flags 0.
- **Leading zeros:** in_exp=15, mant=0_0_0100000000_000 → 16'h3400, exact.
- **Tie rounding:**
  - mant=0_1_0000000001_100 → 16'h3C02, inexact=1.
  - mant=0_1_0000000000_100 → 16'h3C00, inexact=1.
- **Overflow:** in_exp=30, mant=0_1_1111111111_111 → 16'h7C00, overflow=1, inexact=1.
- **Underflow:** in_exp=2, mant=0_0_0010000000_000:
  - With FPU_NORM_SUBNORM_EN → 16'h0100, exact, underflow=0.
  - Without → 16'h0000, underflow=1.
- **Backpressure:** feed 4 back-to-back inputs with out_ready=0 for 3 cycles:
  - in_ready falls after 2 accepts.
  - out_fp stays stable while stalled.
  - After release, all 4 results emerge in order with no gaps.
  - A reset pulse mid-stall clears out_valid the next cycle.
